// File: rtl/remap_axis_out_fifo_if.sv
// AXI4-Stream video beat bundle shared by the remapper input and the FIFO output.
// The receive side has no tready because the remapper transmitter cannot stall.
interface remap_axis_out_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast);
endinterface

// File: rtl/remap_axis_out_fifo.sv
// Output FIFO between the non-stallable remapper stream and a back-pressured AXIS sink,
// with a frame-geometry checker watching every input beat, including dropped ones.
module remap_axis_out_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [12:0]                WIDTH,
  input  logic [12:0]                HEIGHT,
  remap_axis_out_fifo_if.slave       s_axis,
  remap_axis_out_fifo_if.master      m_axis,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic                       o_overflow,
  output logic                       o_err_sof,
  output logic                       o_err_line,
  output logic                       o_err_frame,
  input  logic                       i_clear_err,
  output logic                       o_frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {WAIT_SOF, IN_FRAME} chk_state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   fill_reg;
  logic [EW-1:0] head;
  logic          full, rd_en, wr_en, ovf_evt;

  chk_state_t    state_reg, state_next;
  logic [12:0]   x_reg, x_next, y_reg, y_next, w_reg, w_next, h_reg, h_next;
  logic          sof_evt, line_evt, frame_evt, done_evt, eol;
  logic          ovf_reg, sof_reg, line_reg, frame_reg, done_reg;

  assign full    = (fill_reg == FULL_CNT);
  assign rd_en   = (fill_reg != '0) && m_axis.tready;
  assign wr_en   = s_axis.tvalid && (!full || rd_en);
  assign ovf_evt = s_axis.tvalid && full && !rd_en;

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= {s_axis.tuser, s_axis.tlast, s_axis.tdata};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fill_reg <= fill_reg + 1'b1;
        2'b01:   fill_reg <= fill_reg - 1'b1;
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // Fall-through read of the head entry; masked to zero while empty so stale RAM never leaks out.
  assign head          = mem[rd_ptr_reg];
  assign m_axis.tvalid = (fill_reg != '0);
  assign m_axis.tdata  = m_axis.tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tlast  = m_axis.tvalid & head[DATA_WIDTH];
  assign m_axis.tuser  = m_axis.tvalid & head[DATA_WIDTH+1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= WAIT_SOF;
      x_reg     <= '0;
      y_reg     <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      w_reg     <= w_next;
      h_reg     <= h_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    w_next     = w_reg;
    h_next     = h_reg;
    sof_evt    = 1'b0;
    line_evt   = 1'b0;
    frame_evt  = 1'b0;
    done_evt   = 1'b0;
    eol        = 1'b0;
    if (s_axis.tvalid) begin
      if (s_axis.tuser) begin
        // Any SOF restarts counting with fresh geometry; a one-pixel line also ends on this beat.
        frame_evt = (state_reg == IN_FRAME);
        w_next    = WIDTH;
        h_next    = HEIGHT;
        eol       = (WIDTH == 13'd1);
        line_evt  = (s_axis.tlast != eol);
        if (eol && HEIGHT == 13'd1) begin
          state_next = WAIT_SOF;
          x_next     = '0;
          y_next     = '0;
          done_evt   = 1'b1;
        end else begin
          state_next = IN_FRAME;
          x_next     = eol ? 13'd0 : 13'd1;
          y_next     = eol ? 13'd1 : 13'd0;
        end
      end else if (state_reg == WAIT_SOF) begin
        sof_evt = 1'b1;
      end else begin
        eol      = (x_reg == w_reg - 13'd1);
        line_evt = (s_axis.tlast != eol);
        if (!eol) begin
          x_next = x_reg + 13'd1;
        end else if (y_reg == h_reg - 13'd1) begin
          state_next = WAIT_SOF;
          x_next     = '0;
          y_next     = '0;
          done_evt   = 1'b1;
        end else begin
          x_next = '0;
          y_next = y_reg + 13'd1;
        end
      end
    end
  end

  // A new error event wins over a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_reg   <= 1'b0;
      sof_reg   <= 1'b0;
      line_reg  <= 1'b0;
      frame_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      ovf_reg   <= (ovf_reg   && !i_clear_err) || ovf_evt;
      sof_reg   <= (sof_reg   && !i_clear_err) || sof_evt;
      line_reg  <= (line_reg  && !i_clear_err) || line_evt;
      frame_reg <= (frame_reg && !i_clear_err) || frame_evt;
      done_reg  <= done_evt;
    end
  end

  assign o_fill       = fill_reg;
  assign o_overflow   = ovf_reg;
  assign o_err_sof    = sof_reg;
  assign o_err_line   = line_reg;
  assign o_err_frame  = frame_reg;
  assign o_frame_done = done_reg;
endmodule

// File: tb/tb_remap_axis_out_fifo.sv
// Directed scenario bench for remap_axis_out_fifo (DATA_WIDTH=8, DEPTH=64).
module tb_remap_axis_out_fifo;
  logic        clk = 1'b0;
  logic        rst, clr;
  logic [12:0] width_in, height_in;
  logic [6:0]  fill;
  logic        ovf, esof, eline, eframe, done;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  remap_axis_out_fifo_if #(.DATA_WIDTH(8)) s_if ();
  remap_axis_out_fifo_if #(.DATA_WIDTH(8)) m_if ();
  assign s_if.tready = 1'b0;

  remap_axis_out_fifo #(.DATA_WIDTH(8), .DEPTH(64)) dut (
    .i_clk(clk), .i_reset(rst), .WIDTH(width_in), .HEIGHT(height_in),
    .s_axis(s_if), .m_axis(m_if), .o_fill(fill), .o_overflow(ovf),
    .o_err_sof(esof), .o_err_line(eline), .o_err_frame(eframe),
    .i_clear_err(clr), .o_frame_done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic drive(input logic [7:0] d, input logic u, input logic l);
    s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
    tick();
  endtask

  task automatic set_idle();
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic do_reset();
    set_idle(); clr = 1'b0; m_if.tready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; m_if.tready = 1'b0;
    width_in = 13'd4; height_in = 13'd2;
    s_if.tdata = 8'h5A; s_if.tuser = 1'b0; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    tick(); tick();
    vectors++; if (fill !== 7'd0) begin miscompares++; $display("FAIL reset_fill got %0d want 0", fill); end
    vectors++; if ({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata} !== 11'd0) begin
      miscompares++; $display("FAIL reset_m_axis got v%b u%b l%b d%h want all 0", m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata); end
    vectors++; if ({ovf, esof, eline, eframe, done} !== 5'd0) begin
      miscompares++; $display("FAIL reset_flags got %b want 00000", {ovf, esof, eline, eframe, done}); end
    rst = 1'b0; set_idle();
    tick();
    vectors++; if ({fill, esof} !== 8'd0) begin miscompares++; $display("FAIL reset_ignore got fill %0d sof %b want 0 0", fill, esof); end
  endtask

  task automatic test_frame();
    logic [9:0] exp_beat;
    do_reset();
    width_in = 13'd4; height_in = 13'd2; m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(8'(160 + i), i == 0, i == 3 || i == 7);
      exp_beat = {i == 0, i == 3 || i == 7, 8'(160 + i)};
      vectors++; if (m_if.tvalid !== 1'b1 || {m_if.tuser, m_if.tlast, m_if.tdata} !== exp_beat) begin
        miscompares++; $display("FAIL frame_beat%0d got v%b %h want v1 %h", i, m_if.tvalid, {m_if.tuser, m_if.tlast, m_if.tdata}, exp_beat); end
      vectors++; if (done !== (i == 7)) begin miscompares++; $display("FAIL frame_done_beat%0d got %b want %b", i, done, i == 7); end
    end
    set_idle(); tick();
    vectors++; if (fill !== 7'd0 || m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL frame_drain got fill %0d v%b want 0 0", fill, m_if.tvalid); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL frame_done_count got %0d want 1", done_cnt); end
    vectors++; if ({ovf, esof, eline, eframe} !== 4'd0) begin miscompares++; $display("FAIL frame_flags got %b want 0000", {ovf, esof, eline, eframe}); end
  endtask

  task automatic test_overflow();
    do_reset();
    width_in = 13'd8191; height_in = 13'd8191;
    for (int i = 0; i < 70; i++) begin
      drive(8'(i), i == 0, 1'b0);
      vectors++; if (fill !== 7'((i < 64) ? i + 1 : 64)) begin miscompares++; $display("FAIL ovf_fill_beat%0d got %0d want %0d", i, fill, (i < 64) ? i + 1 : 64); end
      vectors++; if (ovf !== (i >= 64)) begin miscompares++; $display("FAIL ovf_flag_beat%0d got %b want %b", i, ovf, i >= 64); end
    end
    set_idle(); m_if.tready = 1'b1;
    for (int j = 0; j < 64; j++) begin
      vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'(j)) begin
        miscompares++; $display("FAIL ovf_read%0d got v%b d%h want v1 d%h", j, m_if.tvalid, m_if.tdata, 8'(j)); end
      tick();
    end
    vectors++; if (fill !== 7'd0 || m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got fill %0d v%b want 0 0", fill, m_if.tvalid); end
  endtask

  task automatic test_full_passthrough();
    do_reset();
    width_in = 13'd8191; height_in = 13'd8191;
    for (int i = 0; i < 64; i++) drive(8'(i), i == 0, 1'b0);
    vectors++; if (fill !== 7'd64) begin miscompares++; $display("FAIL full_fill got %0d want 64", fill); end
    m_if.tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vectors++; if (m_if.tdata !== 8'(k)) begin miscompares++; $display("FAIL full_head%0d got %h want %h", k, m_if.tdata, 8'(k)); end
      drive(8'(64 + k), 1'b0, 1'b0);
      vectors++; if (fill !== 7'd64 || ovf !== 1'b0) begin miscompares++; $display("FAIL full_pass%0d got fill %0d ovf %b want 64 0", k, fill, ovf); end
    end
    set_idle();
    for (int j = 0; j < 64; j++) begin
      vectors++; if (m_if.tdata !== 8'(10 + j)) begin miscompares++; $display("FAIL full_order%0d got %h want %h", j, m_if.tdata, 8'(10 + j)); end
      tick();
    end
    vectors++; if (fill !== 7'd0) begin miscompares++; $display("FAIL full_empty got %0d want 0", fill); end
  endtask

  task automatic test_line_err();
    do_reset();
    width_in = 13'd4; height_in = 13'd2; m_if.tready = 1'b1;
    drive(8'd1, 1'b1, 1'b0);
    drive(8'd2, 1'b0, 1'b0);
    vectors++; if (eline !== 1'b0) begin miscompares++; $display("FAIL line_early got %b want 0", eline); end
    drive(8'd3, 1'b0, 1'b1);
    vectors++; if (eline !== 1'b1) begin miscompares++; $display("FAIL line_set got %b want 1", eline); end
    set_idle(); clr = 1'b1; tick(); clr = 1'b0;
    vectors++; if (eline !== 1'b0) begin miscompares++; $display("FAIL line_clear got %b want 0", eline); end
    clr = 1'b1; drive(8'd4, 1'b0, 1'b0); clr = 1'b0;
    vectors++; if (eline !== 1'b1) begin miscompares++; $display("FAIL line_clear_collide got %b want 1", eline); end
    set_idle(); tick();
    vectors++; if ({eline, esof, eframe} !== 3'b100) begin miscompares++; $display("FAIL line_sticky got %b want 100", {eline, esof, eframe}); end
  endtask

  task automatic test_sof_frame_err();
    do_reset();
    width_in = 13'd4; height_in = 13'd2; m_if.tready = 1'b1;
    drive(8'h11, 1'b0, 1'b0);
    set_idle(); tick();
    vectors++; if (esof !== 1'b1 || done_cnt !== 0) begin miscompares++; $display("FAIL sof_err got sof %b dones %0d want 1 0", esof, done_cnt); end
    drive(8'd0, 1'b1, 1'b0); drive(8'd1, 1'b0, 1'b0); drive(8'd2, 1'b0, 1'b0); drive(8'd3, 1'b0, 1'b1);
    drive(8'd4, 1'b0, 1'b0); drive(8'd5, 1'b0, 1'b0);
    drive(8'd6, 1'b1, 1'b0);
    vectors++; if (eframe !== 1'b1 || eline !== 1'b0 || done_cnt !== 0) begin
      miscompares++; $display("FAIL frame_err got frame %b line %b dones %0d want 1 0 0", eframe, eline, done_cnt); end
    for (int k = 0; k < 7; k++) drive(8'(k), 1'b0, k == 2 || k == 6);
    vectors++; if (done !== 1'b1 || done_cnt !== 1 || eline !== 1'b0) begin
      miscompares++; $display("FAIL frame_restart got done %b dones %0d line %b want 1 1 0", done, done_cnt, eline); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    width_in = 13'd8; height_in = 13'd8;
    drive(8'hEE, 1'b0, 1'b0);
    for (int f = 0; f < 19; f++) drive(8'(f), f == 0, (f % 8) == 7);
    vectors++; if (fill !== 7'd20 || esof !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got fill %0d sof %b want 20 1", fill, esof); end
    rst = 1'b1;
    s_if.tdata = 8'hFF; s_if.tuser = 1'b0; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    tick();
    rst = 1'b0; set_idle();
    vectors++; if (fill !== 7'd0 || m_if.tvalid !== 1'b0 || {ovf, esof, eline, eframe} !== 4'd0) begin
      miscompares++; $display("FAIL midrst_post got fill %0d v%b flags %b want 0 0 0000", fill, m_if.tvalid, {ovf, esof, eline, eframe}); end
    width_in = 13'd4; height_in = 13'd2; m_if.tready = 1'b1; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(80 + i), i == 0, i == 3 || i == 7);
      vectors++; if (m_if.tdata !== 8'(80 + i)) begin miscompares++; $display("FAIL midrst_beat%0d got %h want %h", i, m_if.tdata, 8'(80 + i)); end
    end
    set_idle(); tick();
    vectors++; if (done_cnt !== 1 || {ovf, esof, eline, eframe} !== 4'd0) begin
      miscompares++; $display("FAIL midrst_frame got dones %0d flags %b want 1 0000", done_cnt, {ovf, esof, eline, eframe}); end
  endtask

  initial begin
    s_if.tdata = '0;
    set_idle();
    test_reset();
    test_frame();
    test_overflow();
    test_full_passthrough();
    test_line_err();
    test_sof_frame_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/remap_axis_out_fifo.md
REMAP_AXIS_OUT_FIFO -- requirements
Module: remap_axis_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: FIFO entries, power of two, minimum 4.
REQ-003 SHALL have i_clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have i_reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have WIDTH, input, 13: active pixels per line, valid range 1..8191.
REQ-006 SHALL have HEIGHT, input, 13: lines per frame, valid range 1..8191.
REQ-007 SHALL have s_axis_tdata/tvalid/tuser/tlast, input, DATA_WIDTH/1/1/1: remapped pixel stream from the remapper transmitter; no tready, because upstream cannot stall.
REQ-008 SHALL have m_axis_tdata/tvalid/tuser/tlast, output, DATA_WIDTH/1/1/1, and m_axis_tready, input, 1: back-pressured AXI4-Stream video output.
REQ-009 SHALL have o_fill, output, clog2(DEPTH)+1: current entry count.
REQ-010 SHALL have o_overflow, o_err_sof, o_err_line, o_err_frame, output, 1 each: sticky error flags.
REQ-011 SHALL have i_clear_err, input, 1: clears all sticky flags; o_frame_done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-012 SHALL store {tuser, tlast, tdata} per entry and output beats in order (FIFO), first-word fall-through.
REQ-013 SHALL write on every cycle with s_axis_tvalid=1 while o_fill<DEPTH, or while o_fill==DEPTH and a read occurs in the same cycle.
REQ-014 SHALL drop a beat with s_axis_tvalid=1 when o_fill==DEPTH and no read occurs, and SHALL set o_overflow; o_fill is unchanged.
REQ-015 SHALL drive m_axis_tvalid=1 iff o_fill>0; a beat written in cycle N SHALL be visible on m_axis in cycle N+1 when the FIFO was empty.
REQ-016 SHALL hold m_axis_tdata/tuser/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; a read occurs iff tvalid and tready are both 1.
REQ-017 SHALL update o_fill as +1 on write only, -1 on read only, and unchanged on simultaneous read and write or on neither; pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL run a geometry checker on every input beat with s_axis_tvalid=1, including dropped beats, with states WAIT_SOF and IN_FRAME and with 13-bit counters x and y.
REQ-019 In WAIT_SOF, a beat with tuser=1 SHALL latch WIDTH/HEIGHT, set x=1, y=0, and go to IN_FRAME (x=0 and y=1 if the latched WIDTH==1); a beat with tuser=0 SHALL set o_err_sof and not be counted.
REQ-020 In IN_FRAME, a beat with tuser=1 SHALL set o_err_frame and restart exactly as in REQ-019.
REQ-021 In IN_FRAME, a beat at x==W-1 SHALL end the line (x=0, y+1); tlast SHALL be 1 exactly on that beat, and any mismatch in either direction SHALL set o_err_line.
REQ-022 The beat at x==W-1 and y==H-1 SHALL return the checker to WAIT_SOF and pulse o_frame_done in the next cycle; W and H are the latched WIDTH and HEIGHT values.
REQ-023 SHALL ignore WIDTH/HEIGHT changes made mid-frame until the next accepted SOF.
REQ-024 SHALL clear sticky flags one cycle after i_clear_err=1; if an error event coincides with i_clear_err, the flag SHALL end up set.

Reset
REQ-025 On i_reset=1 at a clock edge: FIFO empty, o_fill=0, m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, all sticky flags=0, o_frame_done=0, checker in WAIT_SOF with x=y=0.
REQ-026 Reset mid-frame or mid-burst SHALL discard FIFO contents; input beats during reset SHALL be ignored.

Verification
REQ-027 WIDTH=4, HEIGHT=2, m_axis_tready=1, one 8-beat frame (tuser on beat 0, tlast on beats 3 and 7) -> identical 8 beats out, each 1 cycle later; o_frame_done pulses once; all flags stay 0.
REQ-028 DEPTH=64, m_axis_tready=0, 70 consecutive valid beats -> o_fill=64, o_overflow=1 from the 65th beat; then tready=1 -> exactly beats 0..63 out in order.
REQ-029 o_fill=64 with tready=1 and tvalid=1 simultaneously for 10 cycles -> o_fill remains 64, no overflow, ordering preserved.
REQ-030 WIDTH=4, tlast asserted on beat 2 of line 0 -> o_err_line=1; i_clear_err pulse -> 0 next cycle; i_clear_err coinciding with another bad tlast -> flag stays 1.
REQ-031 Beat without tuser after reset -> o_err_sof=1 and no o_frame_done; tuser mid-frame at x=2, y=1 -> o_err_frame=1, counting restarts, next full frame yields o_frame_done.
REQ-032 i_reset=1 for one cycle with o_fill=20 mid-frame -> o_fill=0, m_axis_tvalid=0, flags 0, and the next tuser beat starts a clean frame.
